// File: rtl/calc_sequencer_pkg.sv
// calc_sequencer shared definitions: FSM states, op codes, default width.
// Imported by the sequencer top and its magnitude converter.
package calc_sequencer_pkg;

    localparam int CALC_WIDTH = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV_A,
        ST_CONV_B,
        ST_EXEC,
        ST_FIN,
        ST_DONE
    } calc_state_t;

endpackage

// File: rtl/calc_sequencer_conv.sv
// N-bit two's-complement to sign/magnitude converter (combinational).
// Ports: val (in, N) -> mag (out, N, unsigned), sign (out, 1).
// -2^(N-1) maps to magnitude 2^(N-1), which still fits in N unsigned bits.
module calc_sequencer_conv
    import calc_sequencer_pkg::*;
#(
    parameter int N = CALC_WIDTH
) (
    input  logic [N-1:0] val,
    output logic [N-1:0] mag,
    output logic         sign
);

    assign sign = val[N-1];
    assign mag  = sign ? -val : val;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: multi-cycle add / shift-add multiply controller.
// Ports: clk, rst (sync, active-high), start, op, a[N], b[N] in;
//        busy, done, result[2N], res_sign, res_mag[2N] out.
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int N = CALC_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result,
    output logic           res_sign,
    output logic [2*N-1:0] res_mag
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    calc_state_t state_q, state_d;

    logic           op_q, op_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   mag_a_q, mag_a_d;
    logic           sa_q, sa_d;
    logic           sb_q, sb_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    // Holds the product for multiply and the sign-extended sum for add.
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] result_q, result_d;
    logic           res_sign_q, res_sign_d;
    logic [2*N-1:0] res_mag_q, res_mag_d;

    logic [N-1:0]   conv_in;
    logic [N-1:0]   conv_mag;
    logic           conv_sign;
    logic [2*N-1:0] acc_neg;
    logic [2*N-1:0] sum_ext;
    logic           mul_neg;

    // Single converter, time-shared: A in CONV_A, B at all other times.
    assign conv_in = (state_q == ST_CONV_A) ? a_q : b_q;

    calc_sequencer_conv #(
        .N (N)
    ) u_conv (
        .val  (conv_in),
        .mag  (conv_mag),
        .sign (conv_sign)
    );

    assign acc_neg = -acc_q;
    assign sum_ext = {{N{a_q[N-1]}}, a_q} + {{N{b_q[N-1]}}, b_q};
    // A zero product is reported positive regardless of operand signs.
    assign mul_neg = (sa_q ^ sb_q) && (acc_q != '0);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        mag_a_d    = mag_a_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        res_sign_d = res_sign_q;
        res_mag_d  = res_mag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    state_d = ST_CONV_A;
                end
            end
            ST_CONV_A: begin
                mag_a_d = conv_mag;
                sa_d    = conv_sign;
                state_d = ST_CONV_B;
            end
            ST_CONV_B: begin
                sb_d     = conv_sign;
                mcand_d  = {{N{1'b0}}, mag_a_q};
                mplier_d = conv_mag;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                if (op_q == OP_MUL) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIN;
                    end
                end else begin
                    acc_d   = sum_ext;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                if (op_q == OP_MUL) begin
                    res_sign_d = mul_neg;
                    res_mag_d  = acc_q;
                    result_d   = mul_neg ? acc_neg : acc_q;
                end else begin
                    res_sign_d = acc_q[2*N-1];
                    res_mag_d  = acc_q[2*N-1] ? acc_neg : acc_q;
                    result_d   = acc_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            mag_a_q    <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            res_sign_q <= 1'b0;
            res_mag_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mag_a_q    <= mag_a_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            res_sign_q <= res_sign_d;
            res_mag_q  <= res_mag_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign res_sign = res_sign_q;
    assign res_mag  = res_mag_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (N=8) with immediate assertions.
// Cycle 1 is the edge that samples start; done is checked at its cycle.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        res_sign;
    logic [15:0] res_mag;

    int total = 0;
    int bad   = 0;

    calc_sequencer #(
        .N (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .res_sign (res_sign),
        .res_mag  (res_mag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally poking start with junk operands
    // at cycles poke1/poke2, then check latency, outputs and done width.
    task automatic run_op(input string tag, input logic [7:0] ta,
                          input logic [7:0] tb, input logic top,
                          input int lat, input logic [15:0] eres,
                          input logic esign, input logic [15:0] emag,
                          input int poke1, input int poke2);
        int cyc;
        bit seen;
        @(negedge clk);
        a = ta;
        b = tb;
        op = top;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, busy, 1);
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == poke1 || cyc == poke2) begin
                start = 1'b1;
                a = 8'h7F;
                b = 8'h7F;
                op = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_result"}, result, eres);
        check({tag, "_sign"}, res_sign, esign);
        check({tag, "_mag"}, res_mag, emag);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_busy_drop"}, busy, 0);
        check({tag, "_hold"}, result, eres);
    endtask

    initial begin
        int cyc;
        int dones;
        int busies;

        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int cyc;
        int dones;
        int busies;

        rst = 1'b1;
        start = 1'b0;
        op = 1'b0;
        a = 8'h00;
        b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_sign", res_sign, 0);
        check("rst_mag", res_mag, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_5_m3", 8'h05, 8'hFD, 1'b0, 5,
               16'h0002, 1'b0, 16'h0002, 0, 0);
        run_op("mul_m7_6", 8'hF9, 8'h06, 1'b1, 12,
               16'hFFD6, 1'b1, 16'h002A, 0, 0);
        run_op("mul_m128_m128", 8'h80, 8'h80, 1'b1, 12,
               16'h4000, 1'b0, 16'h4000, 0, 0);
        run_op("add_m128_m128", 8'h80, 8'h80, 1'b0, 5,
               16'hFF00, 1'b1, 16'h0100, 0, 0);
        run_op("mul_0_m5", 8'h00, 8'hFB, 1'b1, 12,
               16'h0000, 1'b0, 16'h0000, 0, 0);
        run_op("mul_127_m128", 8'h7F, 8'h80, 1'b1, 12,
               16'hC080, 1'b1, 16'h3F80, 0, 0);
        run_op("add_m1_m1", 8'hFF, 8'hFF, 1'b0, 5,
               16'hFFFE, 1'b1, 16'h0002, 0, 0);

        // Start pokes while busy must be ignored.
        run_op("busy_rule", 8'hF9, 8'h06, 1'b1, 12,
               16'hFFD6, 1'b1, 16'h002A, 3, 11);
        dones = 0;
        busies = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (busy) busies++;
        end
        check("busy_rule_extra_done", dones, 0);
        check("busy_rule_extra_busy", busies, 0);
        check("idle_hold_result", result, 16'hFFD6);
        check("idle_hold_mag", res_mag, 16'h002A);

        // Reset in the middle of a multiply.
        @(negedge clk);
        a = 8'h05;
        b = 8'h07;
        op = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 6) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_sign", res_sign, 0);
        check("mid_rst_mag", res_mag, 0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("mid_rst_no_done", dones, 0);

        run_op("add_1_1", 8'h01, 8'h01, 1'b0, 5,
               16'h0002, 1'b0, 16'h0002, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Multi-cycle controller for the two-function calculator. It takes two N-bit two's-complement operands and an op select, and computes either A+B or A*B.
- Magnitudes are produced by time-sharing a single N-bit two's-complement-to-magnitude converter.
- The multiply is an N-cycle shift-add on the magnitudes, followed by sign application.
- Delivers a 2N-bit two's-complement result plus sign/magnitude form for the display path.

Parameters:
- N, 8, operand width in bits; result width is 2N.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = add, 1 = multiply; latched with start
- a  input  N  operand A, two's complement; latched with start
- b  input  N  operand B, two's complement; latched with start
- busy  output  1  high from the cycle after start is accepted until DONE is left
- done  output  1  one-cycle pulse; result valid
- result  output  2N  two's-complement result
- res_sign  output  1  1 = result negative
- res_mag  output  2N  unsigned magnitude of result

Behaviour:
- Interface (decided): one clock, clk. rst is synchronous and active-high.
- Reset values: busy=0, done=0, result=0, res_sign=0, res_mag=0. State = IDLE.
- rst has priority at any state, including mid-multiply: return to IDLE, clear all outputs, no done pulse.
- FSM states: IDLE, CONV_A, CONV_B, EXEC, FIN, DONE. Every state except EXEC lasts one cycle.
- IDLE:
  - When start=1, latch a, b and op, then go to CONV_A.
  - When start=0, hold; outputs retain the last result.
- CONV_A: the shared converter input is the latched A; register |A| (N bits, unsigned; -2^(N-1) gives 2^(N-1)). Register sign sA = A[N-1].
- CONV_B: same for B, giving |B| and sB. The converter input mux selects A only in CONV_A and B otherwise.
- EXEC, add (op=0):
  - 1 cycle.
  - sum = sext(A) + sext(B), 2N bits; no overflow is possible.
- EXEC, multiply (op=1):
  - N cycles, counter 0..N-1.
  - Each cycle: if multiplier LSB is 1, acc += multiplicand; then shift multiplicand left 1 and multiplier right 1.
  - acc starts at 0; the unsigned product of |A| and |B| is in acc after N cycles.
- FIN, add: res_sign = sum[2N-1]; res_mag = res_sign ? -sum : sum; result = sum.
- FIN, multiply:
  - res_sign = (sA ^ sB) and (acc != 0), so negative zero is never produced.
  - res_mag = acc; result = res_sign ? -acc : acc.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in CONV_A through DONE inclusive.
- Latency, counted from the clock edge that samples start to done high:
  - add: 5 cycles.
  - multiply: N+4 cycles (12 for N=8).
- start while busy is ignored; it is neither queued nor does it corrupt the latched operands.
- start asserted in the DONE cycle is ignored; it is accepted on the first IDLE cycle.
- Outputs change only in FIN and hold until the next FIN or rst.

Decomposition:
- Shared package: FSM state enum (calc_state_t), op encodings (OP_ADD=0, OP_MUL=1), default width constant.
- One sub-module: the existing N-bit twoSIGN magnitude converter, instantiated exactly once and time-shared between A and B. No second instance is used.
- The 2N-bit negation in FIN is inline RTL.

Test Plan:
- N=8. Add 5 + (-3): a=0x05, b=0xFD, op=0. Expect done at cycle 5; result=0x0002, res_sign=0, res_mag=0x0002.
- Multiply -7 * 6: a=0xF9, b=0x06, op=1. Expect done at cycle 12; result=0xFFD6, res_sign=1, res_mag=0x002A.
- Boundaries:
  - -128 * -128 (a=b=0x80, op=1): result=0x4000, res_sign=0.
  - -128 + -128 (op=0): result=0xFF00, res_sign=1, res_mag=0x0100.
- Zero sign: a=0x00, b=0xFB, op=1. Expect result=0x0000, res_sign=0, res_mag=0.
- Busy rule: start a multiply; assert start with new operands at cycles 3 and 11. Both are ignored, and the first product is correct. A single done pulse occurs, and busy drops the cycle after done.
- Reset mid-operation: rst=1 during EXEC at multiply cycle 4. The next cycle shows busy=0, done=0 and all outputs 0. No done follows. A fresh add 1+1 afterwards returns 0x0002.
